// File: rtl/event_encoder_8to3_pkg.sv
// Shared constants and vector types for the 8-to-3 event encoder.
package event_enc_pkg;
    localparam int N_REQ = 8;
    localparam int IDX_W = $clog2(N_REQ);

    typedef logic [N_REQ-1:0] req_vec_t;
    typedef logic [IDX_W-1:0] req_idx_t;
endpackage

// File: rtl/event_encoder_8to3_if.sv
// Event encoder bus: strobes in, indexed valid/ready channel and status out.
interface event_enc_if;
    import event_enc_pkg::*;

    req_vec_t req_in;
    req_idx_t out_idx;
    logic     out_valid;
    logic     out_ready;
    req_vec_t pending;
    logic     overflow;

    modport master (
        output req_in, out_ready,
        input  out_idx, out_valid, pending, overflow
    );

    modport slave (
        input  req_in, out_ready,
        output out_idx, out_valid, pending, overflow
    );
endinterface

// File: rtl/event_encoder_8to3_pri_enc.sv
// Rotating priority encoder: first set bit at or after i_start, wrapping 7 to 0.
module pri_enc_8to3
    import event_enc_pkg::*;
(
    input  req_vec_t i_vec,
    input  req_idx_t i_start,
    output logic     o_found,
    output req_idx_t o_idx
);
    req_idx_t w_pos;

    // Scan from the farthest offset down so the nearest hit is written last.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_pos   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_pos = i_start + req_idx_t'(k);
            if (i_vec[w_pos]) begin
                o_found = 1'b1;
                o_idx   = w_pos;
            end
        end
    end
endmodule

// File: rtl/event_encoder_8to3.sv
// Sequential 8-to-3 event encoder with pending register and valid/ready output.
// Define ROUND_ROBIN_EN for round-robin selection; default is lowest-index first.
module event_encoder_8to3
    import event_enc_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    event_enc_if.slave   bus
);
    req_vec_t r_pending;
    req_idx_t r_out_idx;
    logic     r_out_valid;
    logic     r_overflow;

    logic     w_load;
    logic     w_found;
    req_idx_t w_sel;
    req_idx_t w_start;
    req_vec_t w_clr_mask;

`ifdef ROUND_ROBIN_EN
    req_idx_t r_last_grant;

    assign w_start = r_last_grant + req_idx_t'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_last_grant <= req_idx_t'(N_REQ - 1);
        else if (w_load && w_found)
            r_last_grant <= w_sel;
    end
`else
    assign w_start = '0;
`endif

    pri_enc_8to3 u_pri_enc (
        .i_vec   (r_pending),
        .i_start (w_start),
        .o_found (w_found),
        .o_idx   (w_sel)
    );

    assign w_load     = !r_out_valid || bus.out_ready;
    assign w_clr_mask = (w_load && w_found) ? (req_vec_t'(1) << w_sel) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending   <= '0;
            r_out_idx   <= '0;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            // Set wins over clear so a same-cycle re-request is a fresh event.
            r_pending  <= (r_pending & ~w_clr_mask) | bus.req_in;
            r_overflow <= |(bus.req_in & r_pending & ~w_clr_mask);
            if (w_load) begin
                r_out_valid <= w_found;
                if (w_found)
                    r_out_idx <= w_sel;
            end
        end
    end

    assign bus.out_idx   = r_out_idx;
    assign bus.out_valid = r_out_valid;
    assign bus.pending   = r_pending;
    assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_event_encoder_8to3.sv
// Directed self-checking bench for event_encoder_8to3.
module tb_event_encoder_8to3;
    import event_enc_pkg::*;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    event_enc_if bus ();

    event_encoder_8to3 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and land 1 time unit after it for sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_in = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        bus.req_in = '0;
        bus.out_ready = 1'b0;
        #2;
        chk("rst_pending", 32'(bus.pending), 32'h00);
        chk("rst_valid",   32'(bus.out_valid), 32'h0);
        chk("rst_idx",     32'(bus.out_idx), 32'h0);
        chk("rst_ovf",     32'(bus.overflow), 32'h0);
        do_reset();

        // Single event on channel 5
        bus.out_ready = 1'b1;
        bus.req_in = 8'h20;
        tick();
        bus.req_in = '0;
        chk("single_pend1",  32'(bus.pending), 32'h20);
        chk("single_vld0",   32'(bus.out_valid), 32'h0);
        tick();
        chk("single_vld",    32'(bus.out_valid), 32'h1);
        chk("single_idx",    32'(bus.out_idx), 32'h5);
        chk("single_pend2",  32'(bus.pending), 32'h00);
        tick();
        chk("single_vld_off", 32'(bus.out_valid), 32'h0);

        // Multi-event: 0,4,7 back to back
        do_reset();
        bus.out_ready = 1'b1;
        bus.req_in = 8'h91;
        tick();
        bus.req_in = '0;
        chk("multi_pend", 32'(bus.pending), 32'h91);
        tick();
        chk("multi_v0", 32'(bus.out_valid), 32'h1);
        chk("multi_i0", 32'(bus.out_idx), 32'h0);
        tick();
        chk("multi_v1", 32'(bus.out_valid), 32'h1);
        chk("multi_i1", 32'(bus.out_idx), 32'h4);
        tick();
        chk("multi_v2", 32'(bus.out_valid), 32'h1);
        chk("multi_i2", 32'(bus.out_idx), 32'h7);
        tick();
        chk("multi_end", 32'(bus.out_valid), 32'h0);
        chk("multi_pend0", 32'(bus.pending), 32'h00);

        // Backpressure with pending 0C
        do_reset();
        bus.out_ready = 1'b0;
        bus.req_in = 8'h0C;
        tick();
        bus.req_in = '0;
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("bp_hold_v", 32'(bus.out_valid), 32'h1);
            chk("bp_hold_i", 32'(bus.out_idx), 32'h2);
            chk("bp_hold_p", 32'(bus.pending), 32'h08);
            chk("bp_ovf",    32'(bus.overflow), 32'h0);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        chk("bp_next_v", 32'(bus.out_valid), 32'h1);
        chk("bp_next_i", 32'(bus.out_idx), 32'h3);
        chk("bp_ovf2",   32'(bus.overflow), 32'h0);
        tick();
        chk("bp_done",   32'(bus.out_valid), 32'h0);

        // Overflow: bit 1 re-requested while still pending
        do_reset();
        bus.out_ready = 1'b0;
        bus.req_in = 8'h03;
        tick();
        bus.req_in = '0;
        tick();
        chk("ovf_hold_i", 32'(bus.out_idx), 32'h0);
        chk("ovf_pend",   32'(bus.pending), 32'h02);
        chk("ovf_none",   32'(bus.overflow), 32'h0);
        bus.req_in = 8'h02;
        tick();
        bus.req_in = '0;
        chk("ovf_pulse",  32'(bus.overflow), 32'h1);
        tick();
        chk("ovf_clear",  32'(bus.overflow), 32'h0);
        bus.out_ready = 1'b1;
        tick();
        chk("ovf_dlv_v",  32'(bus.out_valid), 32'h1);
        chk("ovf_dlv_i",  32'(bus.out_idx), 32'h1);
        tick();
        chk("ovf_once",   32'(bus.out_valid), 32'h0);

        // Set-wins: req on the load cycle of index 1
        do_reset();
        bus.out_ready = 1'b1;
        bus.req_in = 8'h02;
        tick();
        tick();
        bus.req_in = '0;
        chk("sw_v1",   32'(bus.out_valid), 32'h1);
        chk("sw_i1",   32'(bus.out_idx), 32'h1);
        chk("sw_pend", 32'(bus.pending), 32'h02);
        chk("sw_ovf",  32'(bus.overflow), 32'h0);
        tick();
        chk("sw_v2",   32'(bus.out_valid), 32'h1);
        chk("sw_i2",   32'(bus.out_idx), 32'h1);
        chk("sw_p2",   32'(bus.pending), 32'h00);
        tick();
        chk("sw_end",  32'(bus.out_valid), 32'h0);

        // Sustained request on channels 0 and 1
        do_reset();
        bus.out_ready = 1'b1;
        bus.req_in = 8'h03;
        tick();
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("rr_v", 32'(bus.out_valid), 32'h1);
`ifdef ROUND_ROBIN_EN
            chk("rr_i", 32'(bus.out_idx), 32'(c % 2));
`else
            chk("rr_i", 32'(bus.out_idx), 32'h0);
`endif
        end
        bus.req_in = '0;

        // Async reset with pending FF and a held offer
        do_reset();
        bus.out_ready = 1'b0;
        bus.req_in = 8'hFF;
        tick();
        tick();
        chk("ar_pre_p", 32'(bus.pending), 32'hFF);
        chk("ar_pre_v", 32'(bus.out_valid), 32'h1);
        bus.req_in = '0;
        #3;
        rst = 1'b1;
        #1;
        chk("ar_pend",  32'(bus.pending), 32'h00);
        chk("ar_valid", 32'(bus.out_valid), 32'h0);
        chk("ar_idx",   32'(bus.out_idx), 32'h0);
        chk("ar_ovf",   32'(bus.overflow), 32'h0);
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("ar_idle_v", 32'(bus.out_valid), 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
